// File: rtl/agc_pkg.sv
// Shared types, widths and gain helpers for the AGC gain sequencer.
package agc_pkg;

   localparam int unsigned GAIN_W   = 6;
   localparam int unsigned GAIN_MAX = 63;
   localparam int unsigned VGA_W    = 64;
   localparam int unsigned BIT_W    = $clog2(GAIN_W);

   // Sequencer states
   typedef enum logic [2:0] {
      IDLE       = 3'd0,
      SAR_SET    = 3'd1,
      SAR_SETTLE = 3'd2,
      TRACK      = 3'd3,
      EXT        = 3'd4
   } agc_state_e;

   // One gain step up, pinned at full scale
   function automatic logic [GAIN_W-1:0] gain_inc_sat(input logic [GAIN_W-1:0] g);
      return (g == GAIN_W'(GAIN_MAX)) ? g : g + GAIN_W'(1);
   endfunction

   // One gain step down, pinned at zero
   function automatic logic [GAIN_W-1:0] gain_dec_sat(input logic [GAIN_W-1:0] g);
      return (g == GAIN_W'(0)) ? g : g - GAIN_W'(1);
   endfunction

endpackage

// File: rtl/agc_therm_enc.sv
// Combinational gain-code to thermometer encoder for the VGA control word.
module agc_therm_enc
   import agc_pkg::*;
(
   input  logic [GAIN_W-1:0] gain,
   output logic [VGA_W-1:0]  therm_c
);

   // Bit i is set for every step below the gain code; top bit can never be set
   always_comb begin
      therm_c = '0;
      for (int unsigned i = 0; i < VGA_W; i++) begin
         therm_c[i] = (GAIN_W'(i) < gain);
      end
   end

endmodule

// File: rtl/agc_gain_sequencer.sv
// VGA gain sequencer: SAR acquisition against the overload flag, then
// windowed tracking with hysteresis, or external gain passthrough.
module agc_gain_sequencer
   import agc_pkg::*;
#(
   parameter int unsigned SETTLE_CYCLES = 8,
   parameter int unsigned DWELL_CYCLES  = 64,
   parameter int unsigned OVL_THRESH    = 4,
   parameter int unsigned UP_WINDOWS    = 2
)(
   input  logic              clk,
   input  logic              RESETn,
   input  logic              start,
   input  logic              freeze,
   input  logic              overload,
   input  logic              ext_or_int,
   input  logic [GAIN_W-1:0] ext_gain,
   output logic [GAIN_W-1:0] gain_out,
   output logic [VGA_W-1:0]  vga_control,
   output logic              done_out,
   output logic              busy
);

   localparam int unsigned SET_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
   localparam int unsigned WIN_W = $clog2(DWELL_CYCLES);
   localparam int unsigned OVL_W = $clog2(OVL_THRESH + 1);
   localparam int unsigned CLN_W = $clog2(UP_WINDOWS + 1);

   localparam logic [BIT_W-1:0] SAR_TOP = BIT_W'(GAIN_W - 1);

   agc_state_e        state, state_nxt;
   logic [BIT_W-1:0]  bit_idx, bit_nxt;
   logic [GAIN_W-1:0] result, result_nxt;
   logic [GAIN_W-1:0] gain_nxt;
   logic [SET_W-1:0]  settle_cnt, settle_nxt;
   logic [WIN_W-1:0]  win_cnt, win_nxt;
   logic [OVL_W-1:0]  ovl_cnt, ovl_nxt;
   logic [CLN_W-1:0]  clean_cnt, clean_nxt;
   logic              done_nxt, busy_nxt;
   logic [GAIN_W-1:0] trial_c;
   logic [GAIN_W-1:0] sar_res_c;
   logic              ovl_hit_c;
   logic [OVL_W-1:0]  ovl_eff_c;
   logic [VGA_W-1:0]  therm_c;

   // Thermometer code of the gain being registered, so both outputs move together
   agc_therm_enc u_therm_enc (
      .gain    (gain_nxt),
      .therm_c (therm_c)
   );

   // Next-state, counter and gain decisions
   always_comb begin
      state_nxt  = state;
      bit_nxt    = bit_idx;
      result_nxt = result;
      gain_nxt   = gain_out;
      settle_nxt = settle_cnt;
      win_nxt    = win_cnt;
      ovl_nxt    = ovl_cnt;
      clean_nxt  = clean_cnt;

      trial_c   = result | (GAIN_W'(1) << bit_idx);
      sar_res_c = overload ? result : trial_c;
      ovl_hit_c = overload && (win_cnt >= WIN_W'(SETTLE_CYCLES));
      ovl_eff_c = (ovl_hit_c && (ovl_cnt != OVL_W'(OVL_THRESH))) ?
                  ovl_cnt + OVL_W'(1) : ovl_cnt;

      if ((state != IDLE) && (state != EXT) && !ext_or_int) begin
         // Abort to passthrough; gain is held until EXT starts copying
         state_nxt  = EXT;
         bit_nxt    = '0;
         result_nxt = '0;
         settle_nxt = '0;
         win_nxt    = '0;
         ovl_nxt    = '0;
         clean_nxt  = '0;
      end else begin
         unique case (state)
            IDLE: begin
               if (!ext_or_int) begin
                  state_nxt = EXT;
               end else if (start && !freeze) begin
                  bit_nxt    = SAR_TOP;
                  result_nxt = '0;
                  state_nxt  = SAR_SET;
               end
            end
            SAR_SET: begin
               if (!freeze) begin
                  gain_nxt   = trial_c;
                  settle_nxt = '0;
                  state_nxt  = SAR_SETTLE;
               end
            end
            SAR_SETTLE: begin
               if (!freeze) begin
                  settle_nxt = settle_cnt + SET_W'(1);
                  if (settle_cnt == SET_W'(SETTLE_CYCLES - 1)) begin
                     result_nxt = sar_res_c;
                     if (bit_idx != '0) begin
                        bit_nxt   = bit_idx - BIT_W'(1);
                        state_nxt = SAR_SET;
                     end else begin
                        gain_nxt  = sar_res_c;
                        win_nxt   = '0;
                        ovl_nxt   = '0;
                        clean_nxt = '0;
                        state_nxt = TRACK;
                     end
                  end
               end
            end
            TRACK: begin
               if (freeze) begin
                  state_nxt = TRACK;
               end else if (start) begin
                  bit_nxt    = SAR_TOP;
                  result_nxt = '0;
                  state_nxt  = SAR_SET;
               end else if (win_cnt == WIN_W'(DWELL_CYCLES - 1)) begin
                  win_nxt = '0;
                  ovl_nxt = '0;
                  if (ovl_eff_c >= OVL_W'(OVL_THRESH)) begin
                     gain_nxt  = gain_dec_sat(gain_out);
                     clean_nxt = '0;
                  end else if (ovl_eff_c == '0) begin
                     if (clean_cnt == CLN_W'(UP_WINDOWS - 1)) begin
                        gain_nxt  = gain_inc_sat(gain_out);
                        clean_nxt = '0;
                     end else begin
                        clean_nxt = clean_cnt + CLN_W'(1);
                     end
                  end else begin
                     clean_nxt = '0;
                  end
               end else begin
                  win_nxt = win_cnt + WIN_W'(1);
                  ovl_nxt = ovl_eff_c;
               end
            end
            EXT: begin
               gain_nxt = ext_gain;
               if (ext_or_int) begin
                  state_nxt = IDLE;
                  gain_nxt  = gain_out;
               end
            end
            default: begin
               state_nxt = IDLE;
            end
         endcase
      end

      done_nxt = (state_nxt == TRACK);
      busy_nxt = (state_nxt == SAR_SET) || (state_nxt == SAR_SETTLE);
   end

   // State, counter and output registers
   always_ff @(posedge clk or negedge RESETn) begin
      if (!RESETn) begin
         state       <= IDLE;
         bit_idx     <= '0;
         result      <= '0;
         settle_cnt  <= '0;
         win_cnt     <= '0;
         ovl_cnt     <= '0;
         clean_cnt   <= '0;
         gain_out    <= '0;
         vga_control <= '0;
         done_out    <= 1'b0;
         busy        <= 1'b0;
      end else begin
         state       <= state_nxt;
         bit_idx     <= bit_nxt;
         result      <= result_nxt;
         settle_cnt  <= settle_nxt;
         win_cnt     <= win_nxt;
         ovl_cnt     <= ovl_nxt;
         clean_cnt   <= clean_nxt;
         gain_out    <= gain_nxt;
         vga_control <= therm_c;
         done_out    <= done_nxt;
         busy        <= busy_nxt;
      end
   end

endmodule

// File: tb/tb_agc_gain_sequencer.sv
// Self-checking bench for agc_gain_sequencer; overload is modelled as gain_out > target.
module tb_agc_gain_sequencer;

   logic        clk = 1'b0;
   logic        RESETn;
   logic        start;
   logic        freeze;
   logic        ext_or_int;
   logic [5:0]  ext_gain;
   logic [5:0]  target;
   logic        overload;
   logic [5:0]  gain_out;
   logic [63:0] vga_control;
   logic        done_out;
   logic        busy;

   int          n_checks = 0;
   int          n_fail   = 0;
   logic [5:0]  exp_q[$];
   logic [5:0]  prev_gain;
   bit          mon_en = 1'b0;
   int          n;

   assign overload = (gain_out > target);

   always #5 clk = ~clk;

   agc_gain_sequencer dut (
      .clk         (clk),
      .RESETn      (RESETn),
      .start       (start),
      .freeze      (freeze),
      .overload    (overload),
      .ext_or_int  (ext_or_int),
      .ext_gain    (ext_gain),
      .gain_out    (gain_out),
      .vga_control (vga_control),
      .done_out    (done_out),
      .busy        (busy)
   );

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [63:0] therm_ref(input logic [5:0] g);
      logic [63:0] r;
      r = '0;
      for (int i = 0; i < 64; i++) r[i] = (i < int'(g));
      return r;
   endfunction

   // Queue every gain value an acquisition against tgt will show, starting from cur
   function automatic void push_sar(input logic [5:0] tgt, input logic [5:0] cur);
      logic [5:0] res;
      logic [5:0] trial;
      logic [5:0] last;
      res  = '0;
      last = cur;
      for (int b = 5; b >= 0; b--) begin
         trial = res | (6'd1 << b);
         if (trial != last) exp_q.push_back(trial);
         last = trial;
         if (!(trial > tgt)) res = trial;
      end
      if (res != last) exp_q.push_back(res);
   endfunction

   // Scoreboard: each gain change must match the next queued value
   always @(negedge clk) begin
      if (mon_en && (gain_out !== prev_gain)) begin
         if (exp_q.size() == 0) check_val("gain_unexpected", 64'(gain_out), 64'(prev_gain));
         else                   check_val("gain_seq", 64'(gain_out), 64'(exp_q.pop_front()));
         check_val("vga_therm", vga_control, therm_ref(gain_out));
         prev_gain = gain_out;
      end
   end

   task automatic wait_edges(input int k);
      repeat (k) @(posedge clk);
      #1;
   endtask

   // Pulse start and count edges until done_out; optional freeze window and busy-time start
   task automatic run_sar(input int freeze_at, input int start_at, output int cnt);
      @(negedge clk);
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      cnt = 0;
      while (done_out !== 1'b1 && cnt < 300) begin
         if (cnt == freeze_at)      freeze = 1'b1;
         if (cnt == freeze_at + 20) freeze = 1'b0;
         if (cnt == start_at)       start  = 1'b1;
         if (cnt == start_at + 1)   start  = 1'b0;
         @(posedge clk);
         #1;
         cnt++;
      end
      freeze = 1'b0;
      start  = 1'b0;
   endtask

   initial begin
      RESETn     = 1'b0;
      start      = 1'b0;
      freeze     = 1'b0;
      ext_or_int = 1'b1;
      ext_gain   = '0;
      target     = 6'd63;

      #12;
      check_val("rst_gain", 64'(gain_out), 64'd0);
      check_val("rst_vga",  vga_control,   64'd0);
      check_val("rst_done", 64'(done_out), 64'd0);
      check_val("rst_busy", 64'(busy),     64'd0);
      @(negedge clk);
      RESETn    = 1'b1;
      prev_gain = gain_out;
      mon_en    = 1'b1;

      // Full-scale acquisition
      push_sar(6'd63, 6'd0);
      run_sar(-1, -1, n);
      check_val("sar63_latency", 64'(n), 64'd54);
      check_val("sar63_gain", 64'(gain_out), 64'd63);
      check_val("sar63_vga", vga_control, 64'h7FFF_FFFF_FFFF_FFFF);
      check_val("sar63_busy", 64'(busy), 64'd0);

      // Level drops: one step down per window, then a blocked up-trial
      target = 6'd56;
      for (int g = 62; g >= 56; g--) exp_q.push_back(6'(g));
      exp_q.push_back(6'd57);
      exp_q.push_back(6'd56);
      wait_edges(714);
      check_val("track_down_gain", 64'(gain_out), 64'd56);
      check_val("track_down_done", 64'(done_out), 64'd1);

      // Restart from TRACK, acquire 56
      push_sar(6'd56, gain_out);
      run_sar(-1, -1, n);
      check_val("sar56_latency", 64'(n), 64'd54);
      check_val("sar56_gain", 64'(gain_out), 64'd56);

      // Acquire 40, then raise level to 45: one step up per two clean windows
      target = 6'd40;
      push_sar(6'd40, gain_out);
      run_sar(-1, -1, n);
      check_val("sar40_gain", 64'(gain_out), 64'd40);
      target = 6'd45;
      for (int g = 41; g <= 45; g++) exp_q.push_back(6'(g));
      wait_edges(660);
      check_val("track_up_gain", 64'(gain_out), 64'd45);

      // Freeze for 20 cycles mid-acquisition
      target = 6'd20;
      push_sar(6'd20, gain_out);
      run_sar(20, -1, n);
      check_val("freeze_latency", 64'(n), 64'd74);
      check_val("freeze_gain", 64'(gain_out), 64'd20);

      // External passthrough
      exp_q.push_back(6'd17);
      @(negedge clk);
      ext_gain   = 6'd17;
      ext_or_int = 1'b0;
      @(posedge clk);
      #1;
      check_val("ext_done", 64'(done_out), 64'd0);
      check_val("ext_busy", 64'(busy),     64'd0);
      @(posedge clk);
      #1;
      check_val("ext_gain17", 64'(gain_out), 64'd17);
      exp_q.push_back(6'd5);
      ext_gain = 6'd5;
      freeze   = 1'b1;
      @(posedge clk);
      #1;
      check_val("ext_gain5_frozen", 64'(gain_out), 64'd5);
      freeze     = 1'b0;
      ext_or_int = 1'b1;
      wait_edges(3);
      check_val("idle_gain_held", 64'(gain_out), 64'd5);
      check_val("idle_done", 64'(done_out), 64'd0);
      check_val("queue_drain", 64'(exp_q.size()), 64'd0);

      // Asynchronous reset in the middle of an acquisition
      mon_en = 1'b0;
      target = 6'd30;
      @(negedge clk);
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      wait_edges(30);
      check_val("midsar_busy", 64'(busy), 64'd1);
      #2;
      RESETn = 1'b0;
      #1;
      check_val("arst_gain", 64'(gain_out), 64'd0);
      check_val("arst_vga",  vga_control,   64'd0);
      check_val("arst_done", 64'(done_out), 64'd0);
      check_val("arst_busy", 64'(busy),     64'd0);
      exp_q.delete();
      @(negedge clk);
      RESETn    = 1'b1;
      prev_gain = gain_out;
      mon_en    = 1'b1;

      // Reacquire; a start pulse while busy must not disturb it
      push_sar(6'd30, 6'd0);
      run_sar(-1, 20, n);
      check_val("reacq_latency", 64'(n), 64'd54);
      check_val("reacq_gain", 64'(gain_out), 64'd30);

      wait_edges(2);
      check_val("queue_empty", 64'(exp_q.size()), 64'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
